// File: rtl/p2s_sched_pkg.sv
// Shared types and default sizing for the parallel-to-serial round-robin scheduler.
package p2s_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } p2s_state_e;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or above ptr,
// wrapping at NUM_REQ, and reports it as a one-hot grant (gated by en) and an index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Search upward from ptr with explicit wrap; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (en && found) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/p2s_rr_scheduler.sv
// Shares one parallel-to-serial shifter among NUM_REQ requesters. A grant captures the
// winner's word; bits leave MSB-first under valid/ready, and the next grant is taken in
// the cycle the last bit is accepted so consecutive words run without a bubble.
module p2s_rr_scheduler
  import p2s_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*DATA_W-1:0]  data_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic                       serial_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       last_o,
  output logic [$clog2(NUM_REQ)-1:0] src_o,
  output logic                       empty_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  p2s_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [IDX_W-1:0]   src_q, src_d;

  logic               adv;
  logic               at_last;
  logic               opp;
  logic               granted;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [DATA_W-1:0]  win_word;

  assign valid_o  = (state_q == SHIFT);
  assign empty_o  = (state_q == IDLE);
  assign serial_o = valid_o & shreg_q[DATA_W-1];
  assign last_o   = valid_o & (cnt_q == CNT_LAST);
  assign src_o    = src_q;
  assign gnt_o    = arb_gnt;

  assign adv     = valid_o & ready_i;
  assign at_last = valid_o & (cnt_q == CNT_LAST);
  assign opp     = (state_q == IDLE) | (adv & at_last);
  assign granted = |arb_gnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (req_i),
    .ptr (ptr_q),
    .en  (opp),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Select the winning requester's word with a constant-indexed mux.
  always_comb begin
    win_word = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (arb_idx == IDX_W'(r)) begin
        win_word = data_i[r*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and datapath: a grant takes priority over the shift on the last beat.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    src_d   = src_q;
    if (granted) begin
      state_d = SHIFT;
      shreg_d = win_word;
      cnt_d   = '0;
      src_d   = arb_idx;
      ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
    end else if (adv) begin
      if (at_last) begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // State register with synchronous reset; reset also drops any word mid-shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      shreg_q <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      src_q   <= src_d;
    end
  end

endmodule
